hub75_scanner: RTL and testbench
================================

Name: hub75_scanner

Overview:
- Display-side consumer of the pixel framebuffer that the SPI controller loads.
- Scans framebuffer contents out to a HUB75 LED panel, row by row, using binary-code modulation (BCM) over `bitwidth` bit-planes per colour channel.
- Reads the framebuffer through a synchronous read port with 1-cycle latency.
- Pulses `frame_done` at every frame boundary so the system can swap or release buffers.

Parameters:
- segments, 1, parallel panel row groups driven simultaneously (HUB75 upper/lower halves).
- rows, 8, scan rows per segment.
- columns, 32, pixels per row.
- bitwidth, 8, BCM bit-planes per channel; uses channel bits [7:8-bitwidth].
- display_base, 4, OE-active cycles for plane 0; plane p lasts display_base<<p cycles.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- enable  in  1  scan enable; sampled only at frame boundaries.
- rrow  out  $clog2(rows)  framebuffer read row.
- rcol  out  $clog2(columns)  framebuffer read column.
- rdata  in  24*segments  read data, valid the cycle after the address; segment s = bits [24s+23:24s], {R[23:16],G[15:8],B[7:0]}.
- panel_r  out  segments  red serial data, one bit per segment.
- panel_g  out  segments  green serial data.
- panel_b  out  segments  blue serial data.
- panel_clk  out  1  shift clock.
- panel_lat  out  1  latch strobe.
- panel_oe_n  out  1  output enable, active-low.
- panel_addr  out  $clog2(rows)  row select.
- frame_done  out  1  one-cycle pulse at end of frame.

Behaviour:
- All outputs are registered.
- Reset (rst=0 at a clk edge) forces:
  - panel_oe_n=1;
  - panel_clk=0, panel_lat=0;
  - panel_r/g/b=0;
  - panel_addr=0, rrow=0, rcol=0;
  - frame_done=0;
  - state=IDLE, row=0, plane=0.
- Reset taking effect mid-operation blanks the panel on the next cycle and aborts the current row.
- States: IDLE, PREFETCH, SHIFT, LATCH, DISPLAY.
- IDLE:
  - panel_oe_n=1.
  - If enable=1, go to PREFETCH with row=0, plane=0.
- PREFETCH (1 cycle): rrow=row, rcol=0 issued.
- SHIFT (2*columns cycles), for column c:
  - Cycle 2c: panel_clk=0; panel_r/g/b[s] = bit (7-(bitwidth-1-plane)) of the respective channel of segment s of pixel c.
  - Cycle 2c+1: panel_clk=1; data held.
  - The read address for column c+1 is issued in cycle 2c+1.
  - panel_oe_n=1 throughout SHIFT.
- LATCH (1 cycle):
  - panel_clk=0, panel_lat=1, panel_oe_n=1.
  - panel_addr updates to the current row in this cycle only.
- DISPLAY (display_base<<plane cycles):
  - panel_oe_n=0, panel_lat=0.
  - On the last cycle, advance: plane+1. On plane wrap, plane=0 and row+1.
  - On row wrap (row==rows-1, plane==bitwidth-1):
    - frame_done=1 for exactly one cycle, coincident with the first cycle after DISPLAY;
    - row=0;
    - if enable=1 go to PREFETCH, else go to IDLE.
  - Otherwise go to PREFETCH.
- Scan order: plane is the inner loop, row the outer loop.
- Cycles per (row, plane) = 2 + 2*columns + (display_base<<plane).
- Default frame length = 8 * (8*66 + 4*255) = 12384 cycles.
- enable deasserted mid-frame: the frame completes normally, then the block enters IDLE. No partial frames.
- panel_oe_n is never 0 while panel_lat=1 or panel_clk toggles.
- Counters wrap exactly at rows-1, columns-1 and bitwidth-1. Non-power-of-two parameters must not overrun.

Test Plan:
- Reset: hold rst=0 three cycles with enable=1 → panel_oe_n=1, panel_lat=0, panel_clk=0, panel_addr=0, frame_done=0. After release, first PREFETCH reads rrow=0, rcol=0.
- Shift data: model rdata(row,c) = c even ? 24'h800000 : 24'h000001; enable=1.
  - Plane 7 of row 0: 32 rising panel_clk edges; panel_r=1 at even columns; panel_b=0.
  - Plane 0: panel_b=1 at odd columns; panel_r=0.
- BCM timing: count panel_oe_n=0 cycles per DISPLAY for row 0 → 4, 8, 16, …, 512 for planes 0..7. Exactly one panel_lat pulse precedes each DISPLAY, with panel_oe_n=1 during it.
- Row advance and frame:
  - panel_addr takes values 0..7, each held across its 8 planes.
  - frame_done pulses once per 12384 cycles; successive pulses exactly 12384 cycles apart.
  - After the pulse, rrow=0.
- Enable: drop enable at cycle 5000 → scan continues to frame_done, then panel_oe_n stays 1 and panel_clk stays 0. Re-raise enable → next PREFETCH reads row 0.
- Mid-operation reset: assert rst=0 during row 3 plane 6 DISPLAY → panel_oe_n=1 next cycle. After release, restart at row 0 plane 0 and panel_addr=0.

Source files
------------

// File: rtl/hub75_scanner.sv
// hub75_scanner
// -------------
// Reads the pixel framebuffer through a 1-cycle-latency synchronous read port
// and scans it out to a HUB75 LED panel using binary-code modulation (BCM).
// Bit-planes form the inner loop and rows the outer loop. Each (row, plane)
// slot consists of one prefetch cycle, a shift burst of 2*columns cycles, one
// latch cycle and a display window of display_base<<plane cycles.
//
// Every output is a register. Panel pins show the decision the FSM made in the
// previous cycle. The framebuffer address registers are loaded on the state
// transition, so read data for column c is already on rdata in the cycle
// where the FSM decides the panel bits for that column.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-low
//   enable       scan enable, sampled in IDLE and at the end of a frame
//   rrow, rcol   framebuffer read address
//   rdata        read data, 24 bits per segment, {R,G,B}
//   panel_r/g/b  serial colour data, one bit per segment
//   panel_clk    shift clock
//   panel_lat    latch strobe
//   panel_oe_n   output enable, active-low
//   panel_addr   row select
//   frame_done   one-cycle pulse after the last display window of a frame
module hub75_scanner #(
    parameter int unsigned segments     = 1,
    parameter int unsigned rows         = 8,
    parameter int unsigned columns      = 32,
    parameter int unsigned bitwidth     = 8,
    parameter int unsigned display_base = 4,
    localparam int unsigned ROW_W = (rows > 1) ? $clog2(rows) : 1,
    localparam int unsigned COL_W = (columns > 1) ? $clog2(columns) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    output logic [ROW_W-1:0]         rrow,
    output logic [COL_W-1:0]         rcol,
    input  logic [24*segments-1:0]   rdata,
    output logic [segments-1:0]      panel_r,
    output logic [segments-1:0]      panel_g,
    output logic [segments-1:0]      panel_b,
    output logic                     panel_clk,
    output logic                     panel_lat,
    output logic                     panel_oe_n,
    output logic [ROW_W-1:0]         panel_addr,
    output logic                     frame_done
);

    localparam int unsigned PL_W      = (bitwidth > 1) ? $clog2(bitwidth) : 1;
    localparam int unsigned SHIFT_LEN = 2 * columns;
    localparam int unsigned DISP_MAX  = display_base << (bitwidth - 1);
    localparam int unsigned CNT_MAX   = (SHIFT_LEN > DISP_MAX) ? SHIFT_LEN : DISP_MAX;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    // Channel bit used by plane 0; plane p uses bit LSB_BIT + p.
    localparam int unsigned LSB_BIT   = 8 - bitwidth;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] PREFETCH = 3'd1;
    localparam logic [2:0] SHIFT    = 3'd2;
    localparam logic [2:0] LATCH    = 3'd3;
    localparam logic [2:0] DISPLAY  = 3'd4;

    logic [2:0]          state, state_nxt;
    logic [ROW_W-1:0]    row, row_nxt;
    logic [PL_W-1:0]     plane, plane_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [ROW_W-1:0]    rrow_nxt;
    logic [COL_W-1:0]    rcol_nxt;
    logic [segments-1:0] r_nxt, g_nxt, b_nxt;
    logic                pclk_nxt, lat_nxt, oe_n_nxt, done_nxt;
    logic [ROW_W-1:0]    addr_nxt;
    // Frame-wrap flag; delays frame_done so it follows the last lit cycle.
    logic                wrap_q, wrap_nxt;

    logic [2:0]          bit_idx_c;
    logic [segments-1:0] r_bit_c, g_bit_c, b_bit_c;
    logic [CNT_W-1:0]    disp_len_c;
    logic                shift_last_c, col_last_c, disp_last_c;
    logic                plane_last_c, row_last_c;

    // Bit-plane selection from the current read data.
    assign bit_idx_c = 3'(LSB_BIT + 32'(plane));

    for (genvar s = 0; s < segments; s++) begin : g_seg
        logic [7:0] ch_r, ch_g, ch_b;
        assign ch_r       = rdata[24*s+16 +: 8];
        assign ch_g       = rdata[24*s+8  +: 8];
        assign ch_b       = rdata[24*s    +: 8];
        assign r_bit_c[s] = ch_r[bit_idx_c];
        assign g_bit_c[s] = ch_g[bit_idx_c];
        assign b_bit_c[s] = ch_b[bit_idx_c];
    end

    // Terminal-count decodes.
    assign disp_len_c   = CNT_W'(display_base) << plane;
    assign shift_last_c = (cnt == CNT_W'(SHIFT_LEN - 1));
    assign col_last_c   = ((cnt >> 1) == CNT_W'(columns - 1));
    assign disp_last_c  = (cnt == disp_len_c - CNT_W'(1));
    assign plane_last_c = (plane == PL_W'(bitwidth - 1));
    assign row_last_c   = (row == ROW_W'(rows - 1));

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        plane_nxt = plane;
        cnt_nxt   = cnt;
        rrow_nxt  = rrow;
        rcol_nxt  = rcol;
        r_nxt     = panel_r;
        g_nxt     = panel_g;
        b_nxt     = panel_b;
        pclk_nxt  = 1'b0;
        lat_nxt   = 1'b0;
        oe_n_nxt  = 1'b1;
        addr_nxt  = panel_addr;
        wrap_nxt  = 1'b0;
        done_nxt  = wrap_q;

        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = PREFETCH;
                    row_nxt   = '0;
                    plane_nxt = '0;
                    rrow_nxt  = '0;
                    rcol_nxt  = '0;
                end
            end

            PREFETCH: begin
                // Address for column 0 is already on rrow/rcol.
                state_nxt = SHIFT;
                cnt_nxt   = '0;
            end

            SHIFT: begin
                if (!cnt[0]) begin
                    // Data for column cnt/2 is on rdata now; present it with
                    // the clock low, and request the following column.
                    r_nxt    = r_bit_c;
                    g_nxt    = g_bit_c;
                    b_nxt    = b_bit_c;
                    pclk_nxt = 1'b0;
                    if (!col_last_c) begin
                        rcol_nxt = COL_W'(cnt >> 1) + COL_W'(1);
                    end
                end else begin
                    pclk_nxt = 1'b1;
                end
                if (shift_last_c) begin
                    state_nxt = LATCH;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            LATCH: begin
                lat_nxt   = 1'b1;
                addr_nxt  = row;
                state_nxt = DISPLAY;
                cnt_nxt   = '0;
            end

            DISPLAY: begin
                oe_n_nxt = 1'b0;
                if (disp_last_c) begin
                    cnt_nxt   = '0;
                    state_nxt = PREFETCH;
                    if (plane_last_c) begin
                        plane_nxt = '0;
                        if (row_last_c) begin
                            row_nxt  = '0;
                            wrap_nxt = 1'b1;
                            if (!enable) begin
                                state_nxt = IDLE;
                            end
                        end else begin
                            row_nxt = row + ROW_W'(1);
                        end
                    end else begin
                        plane_nxt = plane + PL_W'(1);
                    end
                    rrow_nxt = row_nxt;
                    rcol_nxt = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            row        <= '0;
            plane      <= '0;
            cnt        <= '0;
            rrow       <= '0;
            rcol       <= '0;
            panel_r    <= '0;
            panel_g    <= '0;
            panel_b    <= '0;
            panel_clk  <= 1'b0;
            panel_lat  <= 1'b0;
            panel_oe_n <= 1'b1;
            panel_addr <= '0;
            frame_done <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            row        <= row_nxt;
            plane      <= plane_nxt;
            cnt        <= cnt_nxt;
            rrow       <= rrow_nxt;
            rcol       <= rcol_nxt;
            panel_r    <= r_nxt;
            panel_g    <= g_nxt;
            panel_b    <= b_nxt;
            panel_clk  <= pclk_nxt;
            panel_lat  <= lat_nxt;
            panel_oe_n <= oe_n_nxt;
            panel_addr <= addr_nxt;
            frame_done <= done_nxt;
            wrap_q     <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_hub75_scanner.sv
// Bench for hub75_scanner: a synchronous framebuffer model feeds the DUT, and a
// frame-schedule model predicts every panel pin on every cycle.
module tb_hub75_scanner;

    localparam int ROWS = 8;
    localparam int COLS = 32;
    localparam int BW   = 8;
    localparam int DB   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [2:0]  rrow;
    logic [4:0]  rcol;
    logic [23:0] rdata;
    logic [0:0]  panel_r, panel_g, panel_b;
    logic        panel_clk, panel_lat, panel_oe_n;
    logic [2:0]  panel_addr;
    logic        frame_done;

    hub75_scanner #(
        .segments(1), .rows(ROWS), .columns(COLS), .bitwidth(BW), .display_base(DB)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .rrow(rrow), .rcol(rcol), .rdata(rdata),
        .panel_r(panel_r), .panel_g(panel_g), .panel_b(panel_b),
        .panel_clk(panel_clk), .panel_lat(panel_lat), .panel_oe_n(panel_oe_n),
        .panel_addr(panel_addr), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pat    = 0;

    function automatic logic [23:0] pix(input int mode, input int r, input int c);
        if (mode == 0) return (c % 2 == 0) ? 24'h800000 : 24'h000001;
        return {8'((r * 37 + c * 5 + 3) & 255), 8'((c * 11) ^ (r * 29)), 8'(r + 3 * c + 90)};
    endfunction

    // Framebuffer with one cycle of read latency.
    always @(posedge clk) rdata <= pix(pat, int'(rrow), int'(rcol));

    function automatic int slot_len(input int p);
        return 2 + 2 * COLS + (DB << p);
    endfunction

    function automatic int row_len();
        int s = 0;
        for (int p = 0; p < BW; p++) s += slot_len(p);
        return s;
    endfunction

    // Position within a frame -> row, plane, phase inside the slot.
    function automatic void decode(input int t, output int r, output int p, output int ph);
        int rem;
        r   = t / row_len();
        rem = t % row_len();
        p   = 0;
        while (p < BW - 1 && rem >= slot_len(p)) begin
            rem -= slot_len(p);
            p++;
        end
        ph = rem;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state (pin timeline).
    int frame_len;
    int cyc = 0;
    int m_t = 0, m_frame = 0, m_row = 0, m_plane = 0, m_ph = 0;
    bit m_active = 0, m_launch = 0, m_cont = 0, m_done = 0;

    // Tallies for row 0 of the first frame.
    int oe_cnt[BW], clk_rise[BW], r_one[BW], b_one[BW];
    int lat_n = 0;
    int lat_addr[64];
    int done_cyc[$];
    int first_lat_addr = -1;
    bit after_rst = 0;
    logic prev_clk = 1'b0;

    always @(negedge clk) begin
        logic [23:0] exp_px;
        logic exp_oe, exp_clk, exp_lat;
        int k, bi;
        cyc++;
        if (rst === 1'b0) begin
            m_active = 0; m_launch = 0; m_t = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (m_active) begin
                m_t++;
                if (m_t == frame_len - 1) m_cont = enable;
                if (m_t == frame_len) begin
                    m_done = 1;
                    m_frame++;
                    if (m_cont) m_t = 0;
                    else begin
                        m_active = 0;
                        m_launch = enable;
                    end
                end
            end else if (m_launch) begin
                m_active = 1; m_t = 0; m_launch = 0;
            end else begin
                m_launch = enable;
            end
        end
        if (m_active) decode(m_t, m_row, m_plane, m_ph);
        else begin m_row = 0; m_plane = 0; m_ph = 0; end

        exp_oe = 1'b1; exp_clk = 1'b0; exp_lat = 1'b0;
        chk("frame_done", 32'(frame_done), 32'(m_done));
        if (rst === 1'b0) begin
            chk("rst_addr", 32'(panel_addr), 0);
            chk("rst_r", 32'(panel_r), 0);
            chk("rst_g", 32'(panel_g), 0);
            chk("rst_b", 32'(panel_b), 0);
        end
        if (!m_active) begin
            chk("idle_rrow", 32'(rrow), 0);
        end else if (m_ph == 0) begin
            chk("prefetch_rrow", 32'(rrow), 32'(m_row));
            chk("prefetch_rcol", 32'(rcol), 0);
        end else if (m_ph <= 2 * COLS) begin
            k       = m_ph - 1;
            exp_clk = 1'(k % 2);
            exp_px  = pix(pat, m_row, k / 2);
            bi      = 8 - BW + m_plane;
            chk("panel_r", 32'(panel_r), 32'(exp_px[16 + bi]));
            chk("panel_g", 32'(panel_g), 32'(exp_px[8 + bi]));
            chk("panel_b", 32'(panel_b), 32'(exp_px[bi]));
        end else if (m_ph == 2 * COLS + 1) begin
            exp_lat = 1'b1;
            chk("latch_addr", 32'(panel_addr), 32'(m_row));
        end else begin
            exp_oe = 1'b0;
            chk("display_addr", 32'(panel_addr), 32'(m_row));
        end
        chk("panel_oe_n", 32'(panel_oe_n), 32'(exp_oe));
        chk("panel_clk", 32'(panel_clk), 32'(exp_clk));
        chk("panel_lat", 32'(panel_lat), 32'(exp_lat));

        if (m_active && m_frame == 0 && m_row == 0) begin
            if (panel_oe_n === 1'b0) oe_cnt[m_plane]++;
            if (panel_clk === 1'b1 && prev_clk === 1'b0) begin
                clk_rise[m_plane]++;
                r_one[m_plane] += int'(panel_r);
                b_one[m_plane] += int'(panel_b);
            end
        end
        if (m_active && m_frame == 0 && panel_lat === 1'b1) begin
            if (lat_n < 64) lat_addr[lat_n] = int'(panel_addr);
            lat_n++;
        end
        if (frame_done === 1'b1) done_cyc.push_back(cyc);
        if (after_rst && panel_lat === 1'b1 && first_lat_addr < 0) first_lat_addr = int'(panel_addr);
        prev_clk = panel_clk;
    end

    task automatic wait_frames(input int n, input int budget);
        for (int i = 0; i < budget && m_frame < n; i++) begin
            @(negedge clk); #1;
        end
        chk("frame_timeout", 32'(m_frame >= n), 1);
    endtask

    int bcm_len[BW] = '{4, 8, 16, 32, 64, 128, 256, 512};

    initial begin
        int bad;
        int i;
        rst = 1'b0;
        enable = 1'b1;
        frame_len = ROWS * row_len();
        for (int p = 0; p < BW; p++) begin
            oe_cnt[p] = 0; clk_rise[p] = 0; r_one[p] = 0; b_one[p] = 0;
        end

        // Reset held three cycles with enable high.
        repeat (3) @(negedge clk);
        #1;
        chk("reset_oe_n", 32'(panel_oe_n), 1);
        chk("reset_lat", 32'(panel_lat), 0);
        chk("reset_clk", 32'(panel_clk), 0);
        chk("reset_addr", 32'(panel_addr), 0);
        chk("reset_done", 32'(frame_done), 0);
        chk("reset_rrow", 32'(rrow), 0);
        chk("reset_rcol", 32'(rcol), 0);
        rst = 1'b1;

        // First frame: alternating red / blue columns.
        wait_frames(1, 20000);
        for (int p = 0; p < BW; p++) begin
            chk($sformatf("bcm_len_p%0d", p), 32'(oe_cnt[p]), 32'(bcm_len[p]));
            chk($sformatf("clk_rises_p%0d", p), 32'(clk_rise[p]), 32);
        end
        chk("plane7_red_ones", 32'(r_one[7]), 16);
        chk("plane7_blue_ones", 32'(b_one[7]), 0);
        chk("plane0_red_ones", 32'(r_one[0]), 0);
        chk("plane0_blue_ones", 32'(b_one[0]), 16);
        chk("latch_pulses", 32'(lat_n), 64);
        for (int j = 0; j < 64; j++) chk($sformatf("latch_addr_%0d", j), 32'(lat_addr[j]), 32'(j / 8));

        // Drop enable 5000 cycles into the second frame.
        i = 0;
        while (i < 6000 && !(m_frame == 1 && m_t >= 5000)) begin
            @(negedge clk); #1; i++;
        end
        chk("reach_5000", 32'(m_frame == 1 && m_t >= 5000), 1);
        enable = 1'b0;
        wait_frames(2, 20000);
        chk("done_count_2", 32'(done_cyc.size()), 2);
        if (done_cyc.size() >= 2) chk("frame_period", 32'(done_cyc[1] - done_cyc[0]), 12384);

        bad = 0;
        repeat (300) begin
            @(negedge clk); #1;
            if (panel_oe_n !== 1'b1 || panel_clk !== 1'b0) bad++;
        end
        chk("idle_quiet", 32'(bad), 0);
        chk("idle_no_done", 32'(done_cyc.size()), 2);

        // Re-enable with a richer image, then reset inside row 3 plane 6.
        pat = 1;
        enable = 1'b1;
        i = 0;
        while (i < 20000 && !(m_active && m_row == 3 && m_plane == 6 && m_ph == 2 * COLS + 102)) begin
            @(negedge clk); #1; i++;
        end
        chk("reach_r3p6", 32'(m_active && m_row == 3 && m_plane == 6), 1);
        chk("r3p6_lit", 32'(panel_oe_n), 0);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("midrst_oe_n", 32'(panel_oe_n), 1);
        chk("midrst_addr", 32'(panel_addr), 0);
        @(negedge clk); #1;
        after_rst = 1;
        rst = 1'b1;
        wait_frames(3, 20000);
        chk("restart_addr", 32'(first_lat_addr), 0);
        chk("done_count_3", 32'(done_cyc.size()), 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
